// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, redirect flush, memory-wait freeze
// Mealy control outputs with a RUN/MEM_WAIT/ERROR state register and saturating counters.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic             uses_rt_D,
  input  logic             RegWrite_E,
  input  logic             MemtoReg_E,
  input  logic [4:0]       regD_E,
  input  logic             Branch_D,
  input  logic             taken_D,
  input  logic             Jump_D,
  input  logic             mem_req_M,
  input  logic             mem_ready_M,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic             Bubble_E,
  output logic             Freeze,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              err_q, err_d;

  logic hz_lu, mem_stall, redirect;
  logic run_freeze, run_stall, run_bubble, run_flush;
  logic stall_f_c, stall_d_c, flush_c, bubble_c, freeze_c;

  assign hz_lu = MemtoReg_E & RegWrite_E & (regD_E != 5'd0) &
                 ((regD_E == rs_D) | (uses_rt_D & (regD_E == rt_D)));
  assign mem_stall = mem_req_M & ~mem_ready_M;
  assign redirect  = (Branch_D & taken_D) | Jump_D;

  // Priority: memory stall over load-use over redirect; a suppressed redirect simply reappears later.
  assign run_freeze = mem_stall;
  assign run_stall  = mem_stall | hz_lu;
  assign run_bubble = ~mem_stall & hz_lu;
  assign run_flush  = ~mem_stall & ~hz_lu & redirect;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    freeze_c  = 1'b0;
    case (state_q)
      S_RUN: begin
        freeze_c  = run_freeze;
        stall_f_c = run_stall;
        stall_d_c = run_stall;
        bubble_c  = run_bubble;
        flush_c   = run_flush;
        if (mem_stall) begin
          state_d = S_MEM_WAIT;
          wait_d  = '0;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready_M) begin
          // The access completes now: release in the same cycle and let RUN rules decide.
          freeze_c  = run_freeze;
          stall_f_c = run_stall;
          stall_d_c = run_stall;
          bubble_c  = run_bubble;
          flush_c   = run_flush;
          state_d   = S_RUN;
          wait_d    = '0;
        end else begin
          freeze_c  = 1'b1;
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          if (wait_q == WAIT_MAX) begin
            state_d = S_ERROR;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      S_ERROR: begin
        freeze_c  = 1'b1;
        stall_f_c = 1'b1;
        stall_d_c = 1'b1;
      end
      default: begin
        state_d = S_RUN;
        wait_d  = '0;
      end
    endcase
    if (RESET) begin
      stall_f_c = 1'b0;
      stall_d_c = 1'b0;
      flush_c   = 1'b0;
      bubble_c  = 1'b0;
      freeze_c  = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d_c && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_c && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    err_d = err_q | (state_d == S_ERROR);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign Stall_F   = stall_f_c;
  assign Stall_D   = stall_d_c;
  assign Flush_D   = flush_c;
  assign Bubble_E  = bubble_c;
  assign Freeze    = freeze_c;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
// Driver pushes expected outputs from a cycle-level reference model; monitor pops and compares.
module tb_hazard_ctrl;
  localparam int CNT_W   = 3;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  logic [4:0] rs_D = '0, rt_D = '0, regD_E = '0;
  logic uses_rt_D = 0, RegWrite_E = 0, MemtoReg_E = 0;
  logic Branch_D = 0, taken_D = 0, Jump_D = 0, mem_req_M = 0, mem_ready_M = 0;
  logic Stall_F, Stall_D, Flush_D, Bubble_E, Freeze, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .rs_D(rs_D), .rt_D(rt_D), .uses_rt_D(uses_rt_D),
    .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .regD_E(regD_E),
    .Branch_D(Branch_D), .taken_D(taken_D), .Jump_D(Jump_D),
    .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Bubble_E(Bubble_E),
    .Freeze(Freeze), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit rst; int rs; int rt; bit urt; bit rw; bit m2r; int rd;
    bit br; bit tk; bit jp; bit req; bit rdy;
  } stim_t;

  typedef struct {
    bit sf; bit sd; bit fl; bit bu; bit fr; bit er; int sc; int fc; int id;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_cycle = 0;

  // Reference model: abstract memory-access bookkeeping.
  bit m_waiting = 0, m_dead = 0, m_err = 0;
  int m_waited = 0, m_sc = 0, m_fc = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit hz, redir, ms, sd, fl;
    @(posedge CLOCK);
    #1;
    RESET = s.rst; rs_D = 5'(s.rs); rt_D = 5'(s.rt); uses_rt_D = s.urt;
    RegWrite_E = s.rw; MemtoReg_E = s.m2r; regD_E = 5'(s.rd);
    Branch_D = s.br; taken_D = s.tk; Jump_D = s.jp;
    mem_req_M = s.req; mem_ready_M = s.rdy;

    if (s.rst) begin
      m_waiting = 0; m_dead = 0; m_err = 0; m_waited = 0; m_sc = 0; m_fc = 0;
    end
    hz    = s.m2r && s.rw && s.rd != 0 && (s.rd == s.rs || (s.urt && s.rd == s.rt));
    redir = (s.br && s.tk) || s.jp;
    e = '{default: 0};
    e.id = n_cycle;
    e.sc = m_sc; e.fc = m_fc; e.er = m_err;
    ms = 0;
    if (s.rst) begin
    end else if (m_dead || (m_waiting && !s.rdy)) begin
      e.fr = 1; e.sf = 1; e.sd = 1;
    end else begin
      ms = !m_waiting && s.req && !s.rdy;
      if (ms) begin
        e.fr = 1; e.sf = 1; e.sd = 1;
      end else if (hz) begin
        e.sf = 1; e.sd = 1; e.bu = 1;
      end else if (redir) begin
        e.fl = 1;
      end
    end
    sb.push_back(e);

    sd = e.sd; fl = e.fl;
    if (!s.rst) begin
      if (sd && m_sc < CMAX) m_sc++;
      if (fl && m_fc < CMAX) m_fc++;
      if (m_dead) begin
      end else if (m_waiting) begin
        if (s.rdy) begin
          m_waiting = 0; m_waited = 0;
        end else if (m_waited == TIMEOUT) begin
          m_dead = 1; m_err = 1;
        end else begin
          m_waited++;
        end
      end else if (ms) begin
        m_waiting = 1; m_waited = 0;
      end
    end
    n_cycle++;
  endtask

  task automatic chk(input string name, input int id, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask

  always @(negedge CLOCK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("Stall_F", e.id, int'(Stall_F), int'(e.sf));
      chk("Stall_D", e.id, int'(Stall_D), int'(e.sd));
      chk("Flush_D", e.id, int'(Flush_D), int'(e.fl));
      chk("Bubble_E", e.id, int'(Bubble_E), int'(e.bu));
      chk("Freeze", e.id, int'(Freeze), int'(e.fr));
      chk("err", e.id, int'(err), int'(e.er));
      chk("stall_cnt", e.id, int'(stall_cnt), e.sc);
      chk("flush_cnt", e.id, int'(flush_cnt), e.fc);
    end
  end

  initial begin
    stim_t s;
    int thr;

    // Reset with hazards and redirects present: everything must stay quiet.
    s = idle(); s.rst = 1; s.m2r = 1; s.rw = 1; s.rd = 8; s.rs = 8; s.jp = 1; s.req = 1;
    repeat (2) step(s);

    // Load-use on r8, then the same pattern on r0.
    s = idle(); s.m2r = 1; s.rw = 1; s.rd = 8; s.rs = 8;
    step(s); step(idle());
    s.rd = 0; s.rs = 0;
    step(s); step(idle());

    // Load-use through rt, and rt ignored when not used.
    s = idle(); s.m2r = 1; s.rw = 1; s.rd = 9; s.rt = 9; s.rs = 1; s.urt = 1;
    step(s);
    s.urt = 0;
    step(s);

    // Taken branch, untaken branch, jump, branch colliding with a load-use.
    s = idle(); s.br = 1; s.tk = 1; step(s);
    s.tk = 0; step(s);
    s = idle(); s.jp = 1; step(s);
    s = idle(); s.br = 1; s.tk = 1; s.m2r = 1; s.rw = 1; s.rd = 5; s.rs = 5; step(s);
    step(idle());

    // Memory wait: entry + 3 waiting cycles, then ready with a pending redirect.
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.req = 1;
    repeat (4) step(s);
    s.rdy = 1; s.jp = 1; step(s);
    step(idle());

    // Timeout into ERROR, ready ignored there, then reset recovers.
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.req = 1;
    repeat (10) step(s);
    s.rdy = 1; repeat (2) step(s);
    s = idle(); s.rst = 1; step(s);
    step(idle());
    s = idle(); s.br = 1; s.tk = 1; step(s);

    // Saturation: ten consecutive stall cycles with a 3-bit counter.
    s = idle(); s.rst = 1; step(s);
    s = idle(); s.m2r = 1; s.rw = 1; s.rd = 3; s.rs = 3;
    repeat (10) step(s);
    s = idle(); s.jp = 1;
    repeat (9) step(s);
    step(idle());

    // Randomized traffic with varying memory latency and occasional resets.
    thr = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 3))
          0: thr = 0;
          1: thr = 2;
          2: thr = 6;
          default: thr = 9;
        endcase
      end
      s.rst = ($urandom_range(0, 59) == 0);
      s.rs  = $urandom_range(0, 3);
      s.rt  = $urandom_range(0, 3);
      s.rd  = $urandom_range(0, 3);
      s.urt = $urandom_range(0, 1);
      s.rw  = ($urandom_range(0, 3) != 0);
      s.m2r = $urandom_range(0, 1);
      s.br  = $urandom_range(0, 1);
      s.tk  = $urandom_range(0, 1);
      s.jp  = ($urandom_range(0, 5) == 0);
      s.req = ($urandom_range(0, 5) == 0);
      s.rdy = ($urandom_range(0, 9) < thr);
      step(s);
    end

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge CLOCK);
    @(posedge CLOCK);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum number of MEM_WAIT cycles before the block enters ERROR.
REQ-003 SHALL have port CLOCK  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rs_D / rt_D  input  5 each  source register numbers of the instruction in ID.
REQ-006 SHALL have port uses_rt_D  input  1  the ID instruction reads rt.
REQ-007 SHALL have port RegWrite_E / MemtoReg_E  input  1 each  control bits of the instruction in EX.
REQ-008 SHALL have port regD_E  input  5  destination register of the instruction in EX.
REQ-009 SHALL have port Branch_D / taken_D / Jump_D  input  1 each  branch in ID, branch resolved taken, jump in ID.
REQ-010 SHALL have port mem_req_M / mem_ready_M  input  1 each  MEM stage issues lw/sw; data memory completes this cycle.
REQ-011 SHALL have port Stall_F / Stall_D  output  1 each  hold PC; hold IF_ID (drives IF_ID Stall).
REQ-012 SHALL have port Flush_D  output  1  clear IF_ID (drives IF_ID Flush).
REQ-013 SHALL have port Bubble_E  output  1  insert a NOP into ID_EX.
REQ-014 SHALL have port Freeze  output  1  hold the ID_EX, EX_MEM and MEM_WB registers.
REQ-015 SHALL have port err  output  1  sticky memory-timeout flag.
REQ-016 SHALL have ports stall_cnt / flush_cnt  output  CNT_W each  performance counters.

Function
REQ-017 SHALL implement states RUN, MEM_WAIT and ERROR, with the state held in a register.
REQ-018 SHALL define hz_lu = MemtoReg_E & RegWrite_E & (regD_E!=0) & (regD_E==rs_D | (uses_rt_D & regD_E==rt_D)).
REQ-019 SHALL define mem_stall = mem_req_M & ~mem_ready_M.
REQ-020 SHALL drive all outputs other than the counters and err combinationally from the current state and inputs (Mealy), with zero-cycle latency.
REQ-021 SHALL, in RUN with mem_stall=1, drive Freeze=Stall_F=Stall_D=1 and Flush_D=Bubble_E=0, and enter MEM_WAIT next cycle.
REQ-022 SHALL, in RUN with mem_stall=0 and hz_lu=1, drive Stall_F=Stall_D=Bubble_E=1 and Flush_D=Freeze=0, staying in RUN (one-cycle load-use stall).
REQ-023 SHALL, in RUN with no stall, drive Flush_D=1 when (Branch_D & taken_D) | Jump_D, and all other outputs 0.
REQ-024 SHALL give priority mem_stall > hz_lu > redirect; a redirect coinciding with a stall SHALL NOT flush that cycle and SHALL be re-evaluated after the stall.
REQ-025 SHALL, in MEM_WAIT, drive Freeze=Stall_F=Stall_D=1 and Flush_D=Bubble_E=0, and increment the wait counter each cycle.
REQ-026 SHALL, in MEM_WAIT with mem_ready_M=1, release Freeze in that same cycle (apply RUN rules to the other inputs), clear the wait counter and return to RUN.
REQ-027 SHALL, in MEM_WAIT when the wait counter equals MEM_TIMEOUT and mem_ready_M=0, enter ERROR.
REQ-028 SHALL, in ERROR, hold Freeze=Stall_F=Stall_D=1 and err=1 until RESET; ERROR SHALL have no exit except RESET.
REQ-029 SHALL increment stall_cnt on every cycle with Stall_D=1 and flush_cnt on every cycle with Flush_D=1.
REQ-030 SHALL make both counters saturate at 2^CNT_W-1 with no wrap.
REQ-031 SHALL size the wait counter to hold MEM_TIMEOUT with no wrap.
REQ-032 SHALL never detect a hazard on register 0 (writes to $zero are ignored).

Reset
REQ-033 SHALL, while RESET=1, asynchronously force state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0, err=0, and drive all stall, flush, bubble and freeze outputs to 0 regardless of the other inputs.
REQ-034 SHALL, on RESET asserted mid-MEM_WAIT or in ERROR, abandon the pending access and resume in RUN on the first edge after RESET deasserts.

Verification
REQ-035 SHALL verify load-use: MemtoReg_E=RegWrite_E=1, regD_E=8, rs_D=8 -> Stall_F=Stall_D=Bubble_E=1 for exactly 1 cycle; stall_cnt 0->1.
REQ-036 SHALL verify zero register: same as REQ-035 but regD_E=0, rs_D=0 -> no stall; stall_cnt stays 0.
REQ-037 SHALL verify redirect: Branch_D=taken_D=1, no hazard -> Flush_D=1 for 1 cycle; flush_cnt=1; with hz_lu=1 in the same cycle -> Flush_D=0, Stall_D=1.
REQ-038 SHALL verify memory wait: mem_req_M=1 with mem_ready_M low for 3 cycles then high -> Freeze=1 for 4 cycles (including the entry cycle), Freeze=0 in the ready cycle, back to RUN; stall_cnt=4.
REQ-039 SHALL verify timeout: MEM_TIMEOUT=4, mem_ready_M held 0 -> err=1 after the wait count reaches 4, Freeze stays 1; RESET pulse -> err=0, state RUN, counters 0.
REQ-040 SHALL verify saturation: CNT_W=3, Stall_D held high for 10 cycles -> stall_cnt=7 with no wrap.
